// File: rtl/skindet_pkg.sv
// Shared types and constants for the skin-colour detector controller:
// FSM states, threshold register map, reset thresholds and the window validity rule.
package skindet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_ARMED  = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_TA = 2'd0;
    localparam logic [1:0] ADDR_TB = 2'd1;
    localparam logic [1:0] ADDR_TC = 2'd2;
    localparam logic [1:0] ADDR_TD = 2'd3;

    localparam logic [7:0] THR_TA_RST = 8'd100;
    localparam logic [7:0] THR_TB_RST = 8'd125;
    localparam logic [7:0] THR_TC_RST = 8'd135;
    localparam logic [7:0] THR_TD_RST = 8'd170;

    typedef struct packed {
        logic [7:0] ta;
        logic [7:0] tb;
        logic [7:0] tc;
        logic [7:0] td;
    } thr_t;

    // Both exclusive windows must be non-empty for a threshold set to be usable.
    function automatic logic thr_valid(input thr_t t);
        return (t.ta < t.tb) && (t.tc < t.td);
    endfunction

endpackage

// File: rtl/skindet_thr_regs.sv
// Shadow/active threshold banks: host writes land in shadow, a commit strobe validates and copies.
// Writes take one cycle; o_cfg_rdy drops only while a commit is being applied.
module skindet_thr_regs
    import skindet_pkg::*;
#(
    parameter thr_t RST_THR = {THR_TA_RST, THR_TB_RST, THR_TC_RST, THR_TD_RST}
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_cfg_vld,
    input  logic [1:0] i_cfg_addr,
    input  logic [7:0] i_cfg_dat,
    output logic       o_cfg_rdy,
    input  logic       i_commit,
    output thr_t       o_thr,
    output logic       o_pending,
    output logic       o_cfg_err
);

    thr_t r_shadow;
    thr_t r_active;
    logic r_pending;
    logic r_cfg_err;
    thr_t w_shadow_wr;
    logic w_wr;

    assign o_cfg_rdy = !i_commit;
    assign w_wr      = i_cfg_vld && !i_commit;

    always_comb begin
        w_shadow_wr = r_shadow;
        case (i_cfg_addr)
            ADDR_TA: w_shadow_wr.ta = i_cfg_dat;
            ADDR_TB: w_shadow_wr.tb = i_cfg_dat;
            ADDR_TC: w_shadow_wr.tc = i_cfg_dat;
            ADDR_TD: w_shadow_wr.td = i_cfg_dat;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow  <= RST_THR;
            r_active  <= RST_THR;
            r_pending <= 1'b0;
            r_cfg_err <= 1'b0;
        end else if (i_commit) begin
            r_pending <= 1'b0;
            if (thr_valid(r_shadow)) begin
                r_active  <= r_shadow;
                r_cfg_err <= 1'b0;
            end else begin
                // Rejected set is discarded so the host edits from what is really in use.
                r_shadow  <= r_active;
                r_cfg_err <= 1'b1;
            end
        end else if (w_wr) begin
            r_shadow  <= w_shadow_wr;
            r_pending <= 1'b1;
        end
    end

    assign o_thr     = r_active;
    assign o_pending = r_pending;
    assign o_cfg_err = r_cfg_err;

endmodule

// File: rtl/skindet_ctrl.sv
// Frame-synchronous skin detector controller: enable gating on frame edges, blanking-only threshold
// commits, per-frame saturating skin count reported one cycle after EOF; oCfgReady low on commit cycles.
module skindet_ctrl
    import skindet_pkg::*;
#(
    parameter int         CNT_W  = 20,
    parameter logic [7:0] TA_RST = THR_TA_RST,
    parameter logic [7:0] TB_RST = THR_TB_RST,
    parameter logic [7:0] TC_RST = THR_TC_RST,
    parameter logic [7:0] TD_RST = THR_TD_RST
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iEnable,
    input  logic             iCfgValid,
    input  logic [1:0]       iCfgAddr,
    input  logic [7:0]       iCfgData,
    output logic             oCfgReady,
    input  logic             iFrameValid,
    input  logic             iLineValid,
    input  logic             iSkin,
    output logic [7:0]       oTa,
    output logic [7:0]       oTb,
    output logic [7:0]       oTc,
    output logic [7:0]       oTd,
    output logic             oDetEn,
    output logic [CNT_W-1:0] oSkinCount,
    output logic             oCountValid,
    output logic             oCfgErr
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_fv;
    logic             r_commit_done;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_skin_count;
    logic             r_count_vld;
    logic             w_sof;
    logic             w_eof;
    logic             w_pix;
    logic             w_commit;
    logic             w_start;
    logic             w_frame_end;
    logic             w_pending;
    thr_t             w_thr;

    assign w_sof = iFrameValid && !r_fv;
    assign w_eof = !iFrameValid && r_fv;
    assign w_pix = iSkin && iLineValid && iFrameValid;

    // One commit per blanking, and never on an SOF cycle, so a 1-cycle gap defers it.
    assign w_commit = (r_state == ST_ARMED) && w_pending && !iFrameValid && !r_commit_done;

    always_comb begin
        w_state_nxt = r_state;
        oDetEn      = 1'b0;
        w_start     = 1'b0;
        w_frame_end = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (iEnable) w_state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                if (!iEnable)         w_state_nxt = ST_IDLE;
                else if (!iFrameValid) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
                if (!iEnable) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sof) begin
                    w_state_nxt = ST_ACTIVE;
                    w_start     = 1'b1;
                    oDetEn      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (w_eof) begin
                    w_frame_end = 1'b1;
                    w_state_nxt = iEnable ? ST_ARMED : ST_IDLE;
                end else begin
                    oDetEn = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            r_state       <= ST_IDLE;
            r_fv          <= 1'b0;
            r_commit_done <= 1'b0;
            r_count       <= '0;
            r_skin_count  <= '0;
            r_count_vld   <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_fv          <= iFrameValid;
            r_commit_done <= (r_state == ST_ARMED) && (r_commit_done || w_commit);
            r_count_vld   <= w_frame_end;
            // The SOF cycle already has the mask enabled, so its pixel counts too.
            if (w_start) begin
                r_count <= {{(CNT_W-1){1'b0}}, w_pix};
            end else if ((r_state == ST_ACTIVE) && w_pix && (r_count != CNT_MAX)) begin
                r_count <= r_count + 1'b1;
            end
            if (w_frame_end) r_skin_count <= r_count;
        end
    end

    skindet_thr_regs #(
        .RST_THR ({TA_RST, TB_RST, TC_RST, TD_RST})
    ) u_thr_regs (
        .i_clk      (iClk),
        .i_rst_n    (iRst_n),
        .i_cfg_vld  (iCfgValid),
        .i_cfg_addr (iCfgAddr),
        .i_cfg_dat  (iCfgData),
        .o_cfg_rdy  (oCfgReady),
        .i_commit   (w_commit),
        .o_thr      (w_thr),
        .o_pending  (w_pending),
        .o_cfg_err  (oCfgErr)
    );

    assign oTa         = w_thr.ta;
    assign oTb         = w_thr.tb;
    assign oTc         = w_thr.tc;
    assign oTd         = w_thr.td;
    assign oSkinCount  = r_skin_count;
    assign oCountValid = r_count_vld;

endmodule

// File: tb/tb_skindet_ctrl.sv
// Randomised frame stimulus against a frame-level reference model; two DUTs (CNT_W 20 and 4) share inputs.
module tb_skindet_ctrl;

    localparam int W   = 8;
    localparam int GAP = 2;
    localparam int LN  = 4;
    localparam int FRAME_CYC = 1 + LN * (W + GAP);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, en, cfg_vld, fv, lv, skin;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_dat;

    logic        rdy_a, den_a, cv_a, err_a;
    logic [7:0]  ta_a, tb_a, tc_a, td_a;
    logic [19:0] cnt_a;
    logic        rdy_b, den_b, cv_b, err_b;
    logic [7:0]  ta_b, tb_b, tc_b, td_b;
    logic [3:0]  cnt_b;

    skindet_ctrl #(.CNT_W(20)) u_dut (
        .iClk(clk), .iRst_n(rst_n), .iEnable(en), .iCfgValid(cfg_vld), .iCfgAddr(cfg_addr),
        .iCfgData(cfg_dat), .oCfgReady(rdy_a), .iFrameValid(fv), .iLineValid(lv), .iSkin(skin),
        .oTa(ta_a), .oTb(tb_a), .oTc(tc_a), .oTd(td_a), .oDetEn(den_a), .oSkinCount(cnt_a),
        .oCountValid(cv_a), .oCfgErr(err_a)
    );

    skindet_ctrl #(.CNT_W(4)) u_dut4 (
        .iClk(clk), .iRst_n(rst_n), .iEnable(en), .iCfgValid(cfg_vld), .iCfgAddr(cfg_addr),
        .iCfgData(cfg_dat), .oCfgReady(rdy_b), .iFrameValid(fv), .iLineValid(lv), .iSkin(skin),
        .oTa(ta_b), .oTb(tb_b), .oTc(tc_b), .oTd(td_b), .oDetEn(den_b), .oSkinCount(cnt_b),
        .oCountValid(cv_b), .oCfgErr(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: threshold banks, pending/error flags, frame detection history.
    typedef struct packed {
        logic [7:0]  ta, tb, tc, td;
        logic [31:0] cnt;
    } exp_t;
    typedef struct { int addr; int dat; } wr_t;

    logic [7:0] m_act[4];
    logic [7:0] m_sh[4];
    bit         m_pend, m_err, m_prev_det;
    exp_t       q_start[$];
    exp_t       q_rep[$];
    wr_t        wr_q[$];

    task automatic model_reset();
        m_act[0] = 8'd100; m_act[1] = 8'd125; m_act[2] = 8'd135; m_act[3] = 8'd170;
        m_sh = m_act;
        m_pend = 0; m_err = 0; m_prev_det = 0;
    endtask

    task automatic model_commit();
        if (m_sh[0] < m_sh[1] && m_sh[2] < m_sh[3]) begin
            m_act = m_sh;
            m_err = 0;
        end else begin
            m_sh  = m_act;
            m_err = 1;
        end
        m_pend = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ta"}, ta_a, 100);
        chk({tag, "_tb"}, tb_a, 125);
        chk({tag, "_tc"}, tc_a, 135);
        chk({tag, "_td"}, td_a, 170);
        chk({tag, "_det_en"}, den_a, 0);
        chk({tag, "_count"}, cnt_a, 0);
        chk({tag, "_count_vld"}, cv_a, 0);
        chk({tag, "_cfg_err"}, err_a, 0);
        chk({tag, "_cfg_rdy"}, rdy_a, 1);
        chk({tag, "_ta4"}, ta_b, 100);
        chk({tag, "_count4"}, cnt_b, 0);
    endtask

    // One blanking interval followed by one frame. skin_n<0: random mask, else the first skin_n
    // line pixels are skin. rst_at>=0 pulses reset for two cycles at that frame cycle.
    task automatic run_frame(input int blank_len, input bit en_blank, input bit en_mid,
                             input int skin_n, input bit stall_wr, input int rst_at);
        bit   det;
        int   cnt, pix;
        exp_t e;
        wr_t  w;
        det = en_blank && (blank_len >= 4 || m_prev_det);
        if (en_blank && blank_len >= 4 && m_pend) model_commit();
        for (int b = 0; b < blank_len; b++) begin
            fv = 0; lv = 0; en = en_blank;
            skin = 1'($urandom_range(0, 1));
            cfg_vld = stall_wr && (b == 1 || b == 2);
            cfg_addr = 2'd3; cfg_dat = 8'd200;
            @(negedge clk);
            if (stall_wr && b == 1) chk("cfg_rdy_during_commit", rdy_a, 0);
            if (stall_wr && b == 2) chk("cfg_rdy_after_commit", rdy_a, 1);
            if (b == blank_len - 1) begin
                chk("blank_ta", ta_a, m_act[0]);
                chk("blank_tb", tb_a, m_act[1]);
                chk("blank_tc", tc_a, m_act[2]);
                chk("blank_td", td_a, m_act[3]);
                chk("blank_cfg_err", err_a, m_err);
            end
            @(posedge clk); #1;
        end
        if (stall_wr) begin m_sh[3] = 8'd200; m_pend = 1; end
        cfg_vld = 0;
        e = '{ta: m_act[0], tb: m_act[1], tc: m_act[2], td: m_act[3], cnt: 0};
        if (det) q_start.push_back(e);
        cnt = 0; pix = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            fv = 1;
            lv = (c >= 1) && (((c - 1) % (W + GAP)) < W);
            if (lv && skin_n >= 0) skin = (pix < skin_n);
            else                   skin = 1'($urandom_range(0, 1));
            if (lv) pix++;
            if (lv && skin) cnt++;
            en = (c >= FRAME_CYC / 2) ? en_mid : en_blank;
            rst_n = !(rst_at >= 0 && (c == rst_at || c == rst_at + 1));
            cfg_vld = 0;
            if (c >= 2 && wr_q.size() > 0) begin
                w = wr_q.pop_front();
                cfg_vld = 1; cfg_addr = 2'(w.addr); cfg_dat = 8'(w.dat);
                m_sh[w.addr] = 8'(w.dat);
                m_pend = 1;
            end
            @(negedge clk);
            if (cfg_vld) chk("cfg_rdy_mid_frame", rdy_a, 1);
            if (rst_at >= 0 && c == rst_at + 1) begin
                chk_reset_outputs("mid_frame_reset");
                model_reset();
                det = 0;
            end
            @(posedge clk); #1;
        end
        rst_n = 1;
        cfg_vld = 0;
        e.cnt = cnt;
        if (det) q_rep.push_back(e);
        m_prev_det = det;
    endtask

    // Monitor: pops the scoreboard whenever the DUT opens a frame or reports a count.
    initial begin : monitor
        logic prev_den;
        exp_t e;
        int   sat;
        prev_den = 0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                if (den_a && !prev_den) begin
                    if (q_start.size() == 0) begin
                        chk("det_en_unexpected", den_a, 0);
                    end else begin
                        e = q_start.pop_front();
                        chk("sof_ta", ta_a, e.ta);
                        chk("sof_tb", tb_a, e.tb);
                        chk("sof_tc", tc_a, e.tc);
                        chk("sof_td", td_a, e.td);
                        chk("sof_det_en4", den_b, 1);
                    end
                end
                if (cv_a) begin
                    if (q_rep.size() == 0) begin
                        chk("count_vld_unexpected", cv_a, 0);
                    end else begin
                        e = q_rep.pop_front();
                        sat = (e.cnt > 15) ? 15 : int'(e.cnt);
                        chk("skin_count", cnt_a, e.cnt);
                        chk("skin_count_sat4", cnt_b, sat);
                        chk("count_vld4", cv_b, 1);
                        chk("rep_ta", ta_a, e.ta);
                        chk("rep_tb", tb_a, e.tb);
                        chk("rep_tc", tc_a, e.tc);
                        chk("rep_td", td_a, e.td);
                    end
                end
            end
            prev_den = den_a;
        end
    end

    initial begin
        rst_n = 0; en = 0; cfg_vld = 0; cfg_addr = 0; cfg_dat = 0; fv = 0; lv = 0; skin = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1;

        run_frame(6, 1, 1, 10, 0, -1);                         // 10 skin pixels, reset thresholds
        wr_q.push_back('{0, 90});  run_frame(5, 1, 1, -1, 0, -1); // Ta=90 written mid-frame
        wr_q.push_back('{1, 80});  run_frame(5, 1, 1, -1, 0, -1); // Ta=90 live; Tb=80 pending
        wr_q.push_back('{2, 130}); run_frame(5, 1, 1, -1, 0, -1); // Tb rejected -> error
        run_frame(5, 1, 1, -1, 1, -1);                         // Tc commits, Td write stalls
        run_frame(1, 1, 1, -1, 0, -1);                         // 1-cycle gap defers Td
        run_frame(5, 1, 0, -1, 0, -1);                         // Td commits; enable drops mid-frame
        run_frame(5, 0, 1, -1, 0, -1);                         // enable rises mid-frame: skipped
        run_frame(5, 1, 1, 20, 0, -1);                         // 20 skin: CNT_W=4 saturates
        run_frame(5, 1, 1, -1, 0, 15);                         // reset mid-frame
        run_frame(6, 1, 1, -1, 0, -1);
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                wr_q.push_back('{int'($urandom_range(0, 3)), int'($urandom_range(60, 200))});
            run_frame(int'($urandom_range(4, 7)), 1, 1, -1, 0, -1);
        end

        fv = 0; lv = 0; en = 1;
        repeat (4) @(posedge clk);
        #1;
        @(negedge clk);
        chk("start_queue_drained", q_start.size(), 0);
        chk("report_queue_drained", q_rep.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
